// File: rtl/vga_timing_gen_if.sv
// Pixel/timing bundle between vga_timing_gen (master) and a display consumer (slave).
// The master takes the mode select and external pixel, and drives coordinates, syncs and colour.
interface vga_timing_gen_if #(
   parameter int HW = 10,
   parameter int VW = 10,
   parameter int CW = 4
);
   logic [1:0]    mode;
   logic [CW-1:0] ext_r;
   logic [CW-1:0] ext_g;
   logic [CW-1:0] ext_b;
   logic [HW-1:0] x_o;
   logic [VW-1:0] y_o;
   logic          hsync_o;
   logic          vsync_o;
   logic          de_o;
   logic [CW-1:0] r_o;
   logic [CW-1:0] g_o;
   logic [CW-1:0] b_o;
   logic          frame_start_o;
   logic [1:0]    mode_q_o;

   modport master (
      input  mode, ext_r, ext_g, ext_b,
      output x_o, y_o, hsync_o, vsync_o, de_o, r_o, g_o, b_o, frame_start_o, mode_q_o
   );

   modport slave (
      output mode, ext_r, ext_g, ext_b,
      input  x_o, y_o, hsync_o, vsync_o, de_o, r_o, g_o, b_o, frame_start_o, mode_q_o
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with colour bars, checkerboard and external-pixel sources.
// Stage 0 is the x/y counter pair; every video output is registered from it one clk later.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CW       = 4,
   parameter int CHK_LOG2 = 4
) (
   input  logic             clk,
   input  logic             clr,
   vga_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_N  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_N  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ACT   = 1'(HS_POL);
   localparam logic          VS_ACT   = 1'(VS_POL);
   localparam logic [CW-1:0] FULL     = '1;

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic [HW-1:0] r_bar_pix;
   logic [2:0]    r_bar_idx;

   logic          r_hsync;
   logic          r_vsync;
   logic          r_de;
   logic [CW-1:0] r_r;
   logic [CW-1:0] r_g;
   logic [CW-1:0] r_b;
   logic          r_frame_start;
   logic [1:0]    r_mode_q;

   logic          w_h_last;
   logic          w_v_last;
   logic          w_origin;
   logic          w_active;
   logic          w_hs_on;
   logic          w_vs_on;
   logic [1:0]    w_mode_eff;
   logic [2:0]    w_bar_rgb;
   logic [CW-1:0] w_r;
   logic [CW-1:0] w_g;
   logic [CW-1:0] w_b;

   assign w_h_last = (r_hcnt == H_LAST);
   assign w_v_last = (r_vcnt == V_LAST);
   assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_active = (r_hcnt < H_ACT_N) && (r_vcnt < V_ACT_N);
   assign w_hs_on  = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
   assign w_vs_on  = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
   // The origin pixel already uses the mode being sampled on this edge.
   assign w_mode_eff = w_origin ? vif.mode : r_mode_q;

   // Bar index tracked incrementally so no divider is needed for x/(H_ACTIVE/8).
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_hcnt    <= '0;
         r_vcnt    <= '0;
         r_bar_pix <= '0;
         r_bar_idx <= '0;
      end else if (w_h_last) begin
         r_hcnt    <= '0;
         r_bar_pix <= '0;
         r_bar_idx <= '0;
         r_vcnt    <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
         r_hcnt <= r_hcnt + 1'b1;
         if (r_bar_pix == BAR_LAST) begin
            r_bar_pix <= '0;
            r_bar_idx <= r_bar_idx + 1'b1;
         end else begin
            r_bar_pix <= r_bar_pix + 1'b1;
         end
      end
   end

   always_comb begin
      w_bar_rgb = 3'b000;
      case (r_bar_idx)
         3'd0:    w_bar_rgb = 3'b111;
         3'd1:    w_bar_rgb = 3'b110;
         3'd2:    w_bar_rgb = 3'b011;
         3'd3:    w_bar_rgb = 3'b010;
         3'd4:    w_bar_rgb = 3'b101;
         3'd5:    w_bar_rgb = 3'b100;
         3'd6:    w_bar_rgb = 3'b001;
         default: w_bar_rgb = 3'b000;
      endcase
   end

   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (w_active) begin
         case (w_mode_eff)
            2'd1: begin
               w_r = {CW{w_bar_rgb[2]}};
               w_g = {CW{w_bar_rgb[1]}};
               w_b = {CW{w_bar_rgb[0]}};
            end
            2'd2: begin
               if (r_hcnt[CHK_LOG2] ^ r_vcnt[CHK_LOG2]) begin
                  w_r = FULL;
                  w_g = FULL;
                  w_b = FULL;
               end
            end
            2'd3: begin
               w_r = vif.ext_r;
               w_g = vif.ext_g;
               w_b = vif.ext_b;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_hsync       <= ~HS_ACT;
         r_vsync       <= ~VS_ACT;
         r_de          <= 1'b0;
         r_r           <= '0;
         r_g           <= '0;
         r_b           <= '0;
         r_frame_start <= 1'b0;
         r_mode_q      <= 2'd0;
      end else begin
         r_hsync       <= w_hs_on ? HS_ACT : ~HS_ACT;
         r_vsync       <= w_vs_on ? VS_ACT : ~VS_ACT;
         r_de          <= w_active;
         r_r           <= w_r;
         r_g           <= w_g;
         r_b           <= w_b;
         r_frame_start <= w_origin;
         if (w_origin) begin
            r_mode_q <= vif.mode;
         end
      end
   end

   assign vif.x_o           = r_hcnt;
   assign vif.y_o           = r_vcnt;
   assign vif.hsync_o       = r_hsync;
   assign vif.vsync_o       = r_vsync;
   assign vif.de_o          = r_de;
   assign vif.r_o           = r_r;
   assign vif.g_o           = r_g;
   assign vif.b_o           = r_b;
   assign vif.frame_start_o = r_frame_start;
   assign vif.mode_q_o      = r_mode_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: dut_a uses the 640x480 defaults, dut_b a 14x7 active-high-sync raster
// that is short enough to run whole frames and a mode switch.
module tb_vga_timing_gen;
   logic        clk = 1'b0;
   logic        clr_a;
   logic        clr_b;
   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] exp_q[$];

   vga_timing_gen_if #(.HW(10), .VW(10), .CW(4)) vif_a ();
   vga_timing_gen_if #(.HW(4),  .VW(3),  .CW(4)) vif_b ();

   vga_timing_gen dut_a (
      .clk (clk),
      .clr (clr_a),
      .vif (vif_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .CW(4), .CHK_LOG2(1)
   ) dut_b (
      .clk (clk),
      .clr (clr_b),
      .vif (vif_b)
   );

   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: observed no finish, required finish before 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rgb_a();
      return {20'd0, vif_a.r_o, vif_a.g_o, vif_a.b_o};
   endfunction

   function automatic logic [31:0] rgb_b();
      return {20'd0, vif_b.r_o, vif_b.g_o, vif_b.b_o};
   endfunction

   task automatic wait_a(input int x, input int y);
      int n = 0;
      while (!(int'(vif_a.x_o) == x && int'(vif_a.y_o) == y) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("wait_a", 32'(int'(vif_a.x_o) == x && int'(vif_a.y_o) == y), 32'd1);
   endtask

   task automatic wait_b(input int x, input int y);
      int n = 0;
      while (!(int'(vif_b.x_o) == x && int'(vif_b.y_o) == y) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("wait_b", 32'(int'(vif_b.x_o) == x && int'(vif_b.y_o) == y), 32'd1);
   endtask

   // Leaves the registered outputs showing pixel (x,y).
   task automatic pix_a(input int x, input int y);
      wait_a(x, y);
      @(negedge clk);
   endtask

   task automatic pix_b(input int x, input int y);
      wait_b(x, y);
      @(negedge clk);
   endtask

   initial begin
      int          cyc;
      int          de_cnt;
      int          hs_cnt;
      int          vs_cnt;
      int          fs_cnt;
      int          x_max;
      int          y_max;
      logic        prev_de;
      logic [11:0] val;
      logic [31:0] exp;

      clr_a = 1'b1;
      clr_b = 1'b1;
      vif_a.mode = 2'd1;
      vif_a.ext_r = '0; vif_a.ext_g = '0; vif_a.ext_b = '0;
      vif_b.mode = 2'd1;
      vif_b.ext_r = '0; vif_b.ext_g = '0; vif_b.ext_b = '0;
      #3;
      clr_a = 1'b0;
      clr_b = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_a_x",     32'(vif_a.x_o), 32'd0);
      check("rst_a_y",     32'(vif_a.y_o), 32'd0);
      check("rst_a_de",    32'(vif_a.de_o), 32'd0);
      check("rst_a_rgb",   rgb_a(), 32'h000);
      check("rst_a_fs",    32'(vif_a.frame_start_o), 32'd0);
      check("rst_a_modeq", 32'(vif_a.mode_q_o), 32'd0);
      check("rst_a_hs",    32'(vif_a.hsync_o), 32'd1);
      check("rst_a_vs",    32'(vif_a.vsync_o), 32'd1);
      check("rst_b_hs",    32'(vif_b.hsync_o), 32'd0);
      check("rst_b_vs",    32'(vif_b.vsync_o), 32'd0);

      // Release A: the next edge processes (0,0).
      clr_a = 1'b1;
      @(negedge clk);
      check("a_first_fs",    32'(vif_a.frame_start_o), 32'd1);
      check("a_first_x",     32'(vif_a.x_o), 32'd1);
      check("a_first_modeq", 32'(vif_a.mode_q_o), 32'd1);
      check("a_first_de",    32'(vif_a.de_o), 32'd1);
      check("a_first_rgb",   rgb_a(), 32'hfff);
      check("a_first_hs",    32'(vif_a.hsync_o), 32'd1);
      @(negedge clk);
      check("a_fs_one_cycle", 32'(vif_a.frame_start_o), 32'd0);

      pix_a(79, 0);  check("bar_px79",  rgb_a(), 32'hfff);
      pix_a(80, 0);  check("bar_px80",  rgb_a(), 32'hff0);
      pix_a(159, 0); check("bar_px159", rgb_a(), 32'hff0);
      pix_a(320, 0); check("bar_px320", rgb_a(), 32'hf0f);
      pix_a(639, 0); check("bar_px639", rgb_a(), 32'h000);
      check("de_px639", 32'(vif_a.de_o), 32'd1);
      pix_a(640, 0); check("de_px640",  32'(vif_a.de_o), 32'd0);
      check("rgb_px640", rgb_a(), 32'h000);
      pix_a(655, 0); check("hs_px655", 32'(vif_a.hsync_o), 32'd1);
      pix_a(656, 0); check("hs_px656", 32'(vif_a.hsync_o), 32'd0);
      pix_a(751, 0); check("hs_px751", 32'(vif_a.hsync_o), 32'd0);
      pix_a(752, 0); check("hs_px752", 32'(vif_a.hsync_o), 32'd1);

      // One full line measured from de rising to de rising.
      pix_a(0, 1);
      cyc = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; prev_de = 1'b1;
      do begin
         if (vif_a.de_o) de_cnt++;
         if (!vif_a.hsync_o) hs_cnt++;
         if (!vif_a.vsync_o) vs_cnt++;
         prev_de = vif_a.de_o;
         @(negedge clk);
         cyc++;
      end while (!(vif_a.de_o && !prev_de) && cyc < 2000);
      check("line_period", 32'(cyc), 32'd800);
      check("line_de",     32'(de_cnt), 32'd640);
      check("line_hs_low", 32'(hs_cnt), 32'd96);
      check("line_vs_low", 32'(vs_cnt), 32'd0);

      // Asynchronous clear in the middle of the frame.
      wait_a(300, 20);
      check("pre_clr_de",  32'(vif_a.de_o), 32'd1);
      check("pre_clr_rgb", rgb_a(), 32'h0f0);
      #2;
      clr_a = 1'b0;
      #1;
      check("clr_x",     32'(vif_a.x_o), 32'd0);
      check("clr_y",     32'(vif_a.y_o), 32'd0);
      check("clr_de",    32'(vif_a.de_o), 32'd0);
      check("clr_rgb",   rgb_a(), 32'h000);
      check("clr_hs",    32'(vif_a.hsync_o), 32'd1);
      check("clr_modeq", 32'(vif_a.mode_q_o), 32'd0);
      vif_a.mode = 2'd2;
      @(negedge clk);
      clr_a = 1'b1;
      @(negedge clk);
      check("restart_fs",    32'(vif_a.frame_start_o), 32'd1);
      check("restart_modeq", 32'(vif_a.mode_q_o), 32'd2);
      check("restart_x",     32'(vif_a.x_o), 32'd1);
      check("chk_0_0",       rgb_a(), 32'h000);
      @(negedge clk);
      check("restart_fs_off", 32'(vif_a.frame_start_o), 32'd0);
      pix_a(16, 0);  check("chk_16_0",  rgb_a(), 32'hfff);
      pix_a(0, 16);  check("chk_0_16",  rgb_a(), 32'hfff);
      pix_a(16, 16); check("chk_16_16", rgb_a(), 32'h000);

      // Small raster: whole frame statistics with active-high syncs.
      clr_b = 1'b1;
      @(negedge clk);
      check("b_first_fs",  32'(vif_b.frame_start_o), 32'd1);
      check("b_first_rgb", rgb_b(), 32'hfff);
      check("b_first_hs",  32'(vif_b.hsync_o), 32'd0);
      fs_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; x_max = 0; y_max = 0;
      for (int i = 0; i < 98; i++) begin
         if (vif_b.frame_start_o) fs_cnt++;
         if (vif_b.de_o) de_cnt++;
         if (vif_b.hsync_o) hs_cnt++;
         if (vif_b.vsync_o) vs_cnt++;
         if (int'(vif_b.x_o) > x_max) x_max = int'(vif_b.x_o);
         if (int'(vif_b.y_o) > y_max) y_max = int'(vif_b.y_o);
         @(negedge clk);
      end
      check("b_fs_per_frame", 32'(fs_cnt), 32'd1);
      check("b_de_per_frame", 32'(de_cnt), 32'd32);
      check("b_hs_per_frame", 32'(hs_cnt), 32'd14);
      check("b_vs_per_frame", 32'(vs_cnt), 32'd14);
      check("b_x_max",        32'(x_max), 32'd13);
      check("b_y_max",        32'(y_max), 32'd6);
      check("b_frame_period", 32'(vif_b.frame_start_o), 32'd1);
      pix_b(5, 0); check("b_bar_px5", rgb_b(), 32'hf00);

      // Mode change mid-frame only takes effect at the next origin.
      wait_b(0, 2);
      vif_b.mode = 2'd3;
      pix_b(3, 3);
      check("b_bar_after_switch", rgb_b(), 32'h0f0);
      check("b_modeq_held",       32'(vif_b.mode_q_o), 32'd1);
      wait_b(0, 0);
      check("b_modeq_before_origin", 32'(vif_b.mode_q_o), 32'd1);
      for (int i = 0; i < 15; i++) begin
         if (i > 0) begin
            exp = exp_q.pop_front();
            check("b_ext_px", rgb_b(), exp);
         end
         if (i == 1) begin
            check("b_modeq_new", 32'(vif_b.mode_q_o), 32'd3);
            check("b_fs_new",    32'(vif_b.frame_start_o), 32'd1);
         end
         if (i < 14) begin
            val = 12'($urandom_range(0, 4095));
            vif_b.ext_r = val[11:8];
            vif_b.ext_g = val[7:4];
            vif_b.ext_b = val[3:0];
            exp_q.push_back(i < 8 ? 32'(val) : 32'd0);
            @(negedge clk);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Parameters
REQ-001 The block SHALL have a parameter H_ACTIVE, default 640, giving visible pixels per line; it SHALL be divisible by 8.
REQ-002 The block SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, giving the horizontal front porch, sync and back porch in pixels.
REQ-003 The block SHALL have a parameter V_ACTIVE, default 480, giving visible lines per frame.
REQ-004 The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, giving the vertical porch and sync widths in lines.
REQ-005 The block SHALL have parameters HS_POL and VS_POL, default 0, where 0 means the sync is active-low and 1 means active-high.
REQ-006 The block SHALL have a parameter CW, default 4, giving the bit width of each colour channel.
REQ-007 The block SHALL have a parameter CHK_LOG2, default 4, where the checkerboard square size is 2^CHK_LOG2 pixels.
REQ-008 The block SHALL define the derived values H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, HW = clog2(H_TOTAL) and VW = clog2(V_TOTAL).

Interface
REQ-009 The block SHALL have an input clk, 1 bit wide: the pixel clock, with all flops rising-edge triggered.
REQ-010 The block SHALL have an input clr, 1 bit wide: the reset, asynchronous and active-low (0 = reset).
REQ-011 The block SHALL have an input mode, 2 bits wide: 0 = black, 1 = colour bars, 2 = checkerboard, 3 = external pixel.
REQ-012 The block SHALL have inputs ext_r, ext_g and ext_b, each CW bits wide, carrying the external pixel for coordinate x_o,y_o in the same cycle.
REQ-013 The block SHALL have outputs x_o (HW bits) and y_o (VW bits) carrying the current counter position.
REQ-014 The block SHALL have outputs hsync_o and vsync_o, 1 bit each: the registered sync signals at their parameter polarity.
REQ-015 The block SHALL have an output de_o, 1 bit: the registered data-enable.
REQ-016 The block SHALL have outputs r_o, g_o and b_o, each CW bits wide: the registered colour.
REQ-017 The block SHALL have an output frame_start_o, 1 bit: a one-cycle pulse aligned with the first active pixel of each frame.
REQ-018 The block SHALL have an output mode_q_o, 2 bits: the mode currently in effect.

Function
REQ-019 The horizontal counter SHALL count 0..H_TOTAL-1 and wrap to 0; the vertical counter SHALL increment only when the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0 at that wrap.
REQ-020 Each line SHALL be ordered active, front porch, sync, back porch; the frame SHALL use the same order vertically.
REQ-021 The horizontal sync SHALL be active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, and the vertical sync for the equivalent y range.
REQ-022 The active region SHALL be x < H_ACTIVE and y < V_ACTIVE.
REQ-023 Output latency SHALL be exactly 1 clk: hsync_o, vsync_o, de_o, rgb and frame_start_o SHALL be registered from the stage-0 counter state, so all outputs stay mutually aligned.
REQ-024 Outside the active region, r_o, g_o and b_o SHALL all be 0 regardless of mode.
REQ-025 Mode 0 SHALL output all channels as 0.
REQ-026 Mode 1 SHALL output bar index x/(H_ACTIVE/8), with bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black; each channel is full-scale (all ones) or 0.
REQ-027 Mode 2 SHALL output white when x[CHK_LOG2] XOR y[CHK_LOG2] is 1, and black otherwise.
REQ-028 Mode 3 SHALL register ext_r, ext_g and ext_b sampled in the cycle x_o,y_o is presented.
REQ-029 The mode input SHALL be sampled into mode_q_o only in the cycle the counters are at x=0,y=0, so a mode change takes effect from the first pixel of the next frame and never mid-frame.
REQ-030 At x=0,y=0 the colour SHALL be computed with the newly sampled mode.
REQ-031 frame_start_o SHALL be 1 for exactly the one clk in which the output corresponds to x=0,y=0.
REQ-032 The block SHALL contain no combinational path from any input to hsync_o, vsync_o, de_o or rgb.

Reset
REQ-033 While clr=0, both counters, de_o, rgb, frame_start_o and mode_q_o SHALL be 0.
REQ-034 While clr=0, hsync_o SHALL equal ~HS_POL and vsync_o SHALL equal ~VS_POL (the inactive levels).
REQ-035 Assertion of clr mid-frame SHALL take effect immediately (asynchronous).
REQ-036 After clr is released, the first clk edge SHALL process x=0,y=0, so frame_start_o pulses one clk after release and the mode is sampled then.

Verification
REQ-037 Defaults, mode=1, run 2 frames -> line period 800 clk, frame 420000 clk; hsync_o low for 96 clk starting 656 clk after de_o rises; vsync_o low for lines 490-491; de_o high 640 clk per line on 480 lines.
REQ-038 Mode 1, line 0 -> pixels 0-79 rgb=F/F/F; 80-159 F/F/0; 560-639 0/0/0; de_o=0 and rgb=0 at pixel 640.
REQ-039 Mode 2 -> pixel (16,0) white, (0,0) black, (16,16) black.
REQ-040 Switch mode 1->3 at line 100 -> bars continue to the frame end; mode_q_o changes in the x=0,y=0 cycle; next frame outputs ext_* with 1 clk delay relative to x_o.
REQ-041 HS_POL=1, VS_POL=1, with the small timing H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> line of 14 clk, frame of 7 lines, syncs active-high, counters wrap cleanly.
REQ-042 Pulse clr low at x=300,y=200 -> outputs go to reset values without waiting for a clk edge; after release the frame restarts at 0,0 and frame_start_o pulses one clk later.
